spec_step_seq: RTL and testbench

SPEC_STEP_SEQ -- requirements
Module: spec_step_seq

---
 rtl/spec_step_pkg.sv | 30 +++
 rtl/spec_gran_collect.sv | 126 ++++++++++++
 rtl/spec_step_seq.sv | 185 ++++++++++++++++++
 tb/tb_spec_step_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spec_step_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spec_step_pkg
// Purpose  : Shared types and constants for the spec step sequencer:
//            step-mode enum, sequencer state enum, RV32 granule width.
// Revision : 1.0 - initial release
// ============================================================================
package spec_step_pkg;

  // Width of one memory granule / data word on RV32.
  localparam int GRAN_W = 32;

  typedef enum logic [1:0] {
    MODE_STEP  = 2'd0,
    MODE_RUN   = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_RSVD  = 2'd3
  } spec_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EXEC     = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_COMMIT   = 3'd3,
    ST_ERROR    = 3'd4
  } spec_state_e;

endpackage
`default_nettype wire

// File: rtl/spec_gran_collect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spec_gran_collect
// Purpose  : Memory granule collector. Decodes the per-granule request mask
//            into a granule count, tracks which granule is awaited, stores
//            returned read data and (optionally) times out a stalled read.
// Ports    : clk_i/rst_i     clock, synchronous active-high reset
//            clear_i         new instruction: clear counter and buffer
//            start_i         entering MEM_WAIT: capture the granule count
//            active_i        sequencer is in MEM_WAIT
//            req_i/addr_i    per-granule request mask and addresses
//            rvalid_i/rdata_i returned read data
//            needed_o/contig_o decoded count and mask contiguity
//            done_o          last awaited granule arrives this cycle
//            timeout_o       read stalled too long
//            addr_o/buf_o    address of awaited granule, collected data
// Config   : SPEC_STEP_MEM_TIMEOUT_EN enables the MEM_WAIT timeout counter.
// Revision : 1.0 - initial release
// ============================================================================
module spec_gran_collect
  import spec_step_pkg::*;
#(
  parameter int MemGrans      = 2,
  parameter int TimeoutCycles = 16,
  localparam int CW           = $clog2(MemGrans + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       start_i,
  input  logic                       active_i,
  input  logic [MemGrans-1:0]        req_i,
  input  logic [GRAN_W*MemGrans-1:0] addr_i,
  input  logic                       rvalid_i,
  input  logic [GRAN_W-1:0]          rdata_i,
  output logic [CW-1:0]              needed_o,
  output logic                       contig_o,
  output logic                       done_o,
  output logic                       timeout_o,
  output logic [GRAN_W-1:0]          addr_o,
  output logic [GRAN_W*MemGrans-1:0] buf_o
);

  logic [CW-1:0]                      k_q, k_d;
  logic [CW-1:0]                      needed_q, needed_d;
  logic [MemGrans-1:0][GRAN_W-1:0]    buf_q, buf_d;
  logic                               seen_zero;

  // Count leading ones; any set bit after a clear bit breaks contiguity.
  always_comb begin
    needed_o  = '0;
    contig_o  = 1'b1;
    seen_zero = 1'b0;
    for (int g = 0; g < MemGrans; g++) begin
      if (req_i[g]) begin
        if (seen_zero) contig_o = 1'b0;
        else           needed_o = needed_o + CW'(1);
      end else begin
        seen_zero = 1'b1;
      end
    end
  end

  always_comb begin
    k_d      = k_q;
    needed_d = needed_q;
    buf_d    = buf_q;
    if (clear_i) begin
      k_d   = '0;
      buf_d = '0;
    end
    if (start_i) needed_d = needed_o;
    if (active_i && rvalid_i) begin
      for (int g = 0; g < MemGrans; g++) begin
        if (k_q == CW'(g)) buf_d[g] = rdata_i;
      end
      k_d = k_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q      <= '0;
      needed_q <= '0;
      buf_q    <= '0;
    end else begin
      k_q      <= k_d;
      needed_q <= needed_d;
      buf_q    <= buf_d;
    end
  end

  always_comb begin
    addr_o = '0;
    for (int g = 0; g < MemGrans; g++) begin
      if (k_q == CW'(g)) addr_o = addr_i[g*GRAN_W +: GRAN_W];
    end
  end

  assign done_o = active_i && rvalid_i && ((k_q + CW'(1)) == needed_q);
  assign buf_o  = buf_q;

`ifdef SPEC_STEP_MEM_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Counts consecutive MEM_WAIT cycles without returned data.
  always_comb begin
    tmo_d = tmo_q;
    if (start_i || (active_i && rvalid_i)) tmo_d = '0;
    else if (active_i)                     tmo_d = tmo_q + TW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end

  assign timeout_o = active_i && !rvalid_i && (tmo_q == TW'(TimeoutCycles - 1));
`else
  assign timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/spec_step_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spec_step_seq
// Purpose  : Single-step sequencer around an external instruction spec.
//            Accepts one instruction, collects the memory granules the spec
//            asks for, then commits the spec's register write and next PC
//            into a shadow architectural state.
// Ports    : instr_*       instruction handshake and latched copy
//            spec_*        shadow state out / spec results in
//            mem_*         granule read port
//            commit_*      one-cycle commit report
//            err_o         sticky error (cleared only by rst_i)
// Config   : SPEC_STEP_MEM_TIMEOUT_EN enables the MEM_WAIT timeout.
// Revision : 1.0 - initial release
// ============================================================================
module spec_step_seq
  import spec_step_pkg::*;
#(
  parameter int          NREGS         = 32,
  parameter int          MemGrans      = 2,
  parameter logic [31:0] ResetPc       = 32'h0000_0080,
  parameter int          TimeoutCycles = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       instr_valid_i,
  output logic                       instr_ready_o,
  input  logic [31:0]                instr_bits_i,
  input  logic [1:0]                 instr_mode_i,
  output logic [32*(NREGS-1)-1:0]    spec_regs_o,
  output logic [31:0]                spec_pc_o,
  output logic [31:0]                spec_insn_o,
  output logic [1:0]                 spec_mode_o,
  output logic [GRAN_W*MemGrans-1:0] spec_mem_rdata_o,
  input  logic                       spec_wx_en_i,
  input  logic [4:0]                 spec_wx_addr_i,
  input  logic [31:0]                spec_wx_i,
  input  logic [31:0]                spec_nextpc_i,
  input  logic                       spec_err_i,
  input  logic [MemGrans-1:0]        spec_mem_req_i,
  input  logic [GRAN_W*MemGrans-1:0] spec_mem_addr_i,
  output logic                       mem_req_o,
  output logic [31:0]                mem_addr_o,
  input  logic                       mem_rvalid_i,
  input  logic [31:0]                mem_rdata_i,
  output logic                       commit_valid_o,
  output logic [31:0]                commit_pc_o,
  output logic                       commit_wx_en_o,
  output logic [4:0]                 commit_wx_addr_o,
  output logic [31:0]                commit_wx_o,
  output logic                       err_o
);

  localparam int CW = $clog2(MemGrans + 1);

  spec_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] insn_q, insn_d;
  spec_mode_e  mode_q, mode_d;
  logic [31:0] regs_q [1:NREGS-1];
  logic [31:0] regs_d [1:NREGS-1];

  logic [CW-1:0]              needed;
  logic                       contig, done, timeout;
  logic [GRAN_W-1:0]          gran_addr;
  logic [GRAN_W*MemGrans-1:0] gran_buf;
  logic                       accept, bad_wr, commit_fire;

  assign accept = (state_q == ST_IDLE) && instr_valid_i && !mem_rvalid_i;
  // Only reachable when NREGS < 32.
  assign bad_wr = spec_wx_en_i && ({27'd0, spec_wx_addr_i} >= 32'(NREGS));
  // A COMMIT cycle that also detects an error does not commit.
  assign commit_fire = (state_q == ST_COMMIT) && !spec_err_i && !mem_rvalid_i && !bad_wr;

  spec_gran_collect #(
    .MemGrans      (MemGrans),
    .TimeoutCycles (TimeoutCycles)
  ) u_collect (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (accept),
    .start_i   ((state_q == ST_EXEC) && (state_d == ST_MEM_WAIT)),
    .active_i  (state_q == ST_MEM_WAIT),
    .req_i     (spec_mem_req_i),
    .addr_i    (spec_mem_addr_i),
    .rvalid_i  (mem_rvalid_i),
    .rdata_i   (mem_rdata_i),
    .needed_o  (needed),
    .contig_o  (contig),
    .done_o    (done),
    .timeout_o (timeout),
    .addr_o    (gran_addr),
    .buf_o     (gran_buf)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_rvalid_i)       state_d = ST_ERROR;
        else if (instr_valid_i) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (spec_err_i || mem_rvalid_i || !contig) state_d = ST_ERROR;
        else if (needed == '0)                     state_d = ST_COMMIT;
        else                                       state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (spec_err_i || timeout) state_d = ST_ERROR;
        else if (done)             state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (spec_err_i || mem_rvalid_i || bad_wr) state_d = ST_ERROR;
        else                                      state_d = ST_IDLE;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  // Output logic; reset forces the idle-looking output set immediately.
  always_comb begin
    instr_ready_o    = rst_i || (state_q == ST_IDLE);
    err_o            = !rst_i && (state_q == ST_ERROR);
    mem_req_o        = !rst_i && (state_q == ST_MEM_WAIT);
    mem_addr_o       = mem_req_o ? gran_addr : 32'd0;
    commit_valid_o   = !rst_i && commit_fire;
    commit_pc_o      = commit_valid_o ? pc_q : 32'd0;
    commit_wx_en_o   = commit_valid_o && spec_wx_en_i && (spec_wx_addr_i != 5'd0);
    commit_wx_addr_o = commit_valid_o ? spec_wx_addr_i : 5'd0;
    commit_wx_o      = commit_valid_o ? spec_wx_i : 32'd0;
    spec_pc_o        = rst_i ? ResetPc : pc_q;
    spec_insn_o      = rst_i ? 32'd0 : insn_q;
    spec_mode_o      = rst_i ? 2'd0 : mode_q;
    spec_mem_rdata_o = rst_i ? '0 : gran_buf;
  end

  // Shadow architectural state
  always_comb begin
    pc_d   = pc_q;
    insn_d = insn_q;
    mode_d = mode_q;
    regs_d = regs_q;
    if (accept) begin
      insn_d = instr_bits_i;
      mode_d = spec_mode_e'(instr_mode_i);
    end
    if (commit_fire) begin
      pc_d = spec_nextpc_i;
      if (spec_wx_en_i) begin
        for (int i = 1; i < NREGS; i++) begin
          if (spec_wx_addr_i == 5'(i)) regs_d[i] = spec_wx_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q   <= ResetPc;
      insn_q <= '0;
      mode_q <= MODE_STEP;
      for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      pc_q   <= pc_d;
      insn_q <= insn_d;
      mode_q <= mode_d;
      regs_q <= regs_d;
    end
  end

  for (genvar i = 1; i < NREGS; i++) begin : g_regs_out
    assign spec_regs_o[(i-1)*32 +: 32] = rst_i ? 32'd0 : regs_q[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_spec_step_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spec_step_seq
// Purpose  : Directed self-checking bench for spec_step_seq: a table of
//            no-memory instructions plus hand sequences for granule reads,
//            reset during MEM_WAIT, error entry and the MEM_WAIT timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spec_step_seq;

  localparam int NREGS = 32;
  localparam int MG    = 2;
  localparam int TO    = 8;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic                  instr_valid_i;
  logic                  instr_ready_o;
  logic [31:0]           instr_bits_i;
  logic [1:0]            instr_mode_i;
  logic [32*(NREGS-1)-1:0] spec_regs_o;
  logic [31:0]           spec_pc_o;
  logic [31:0]           spec_insn_o;
  logic [1:0]            spec_mode_o;
  logic [32*MG-1:0]      spec_mem_rdata_o;
  logic                  spec_wx_en_i;
  logic [4:0]            spec_wx_addr_i;
  logic [31:0]           spec_wx_i;
  logic [31:0]           spec_nextpc_i;
  logic                  spec_err_i;
  logic [MG-1:0]         spec_mem_req_i;
  logic [32*MG-1:0]      spec_mem_addr_i;
  logic                  mem_req_o;
  logic [31:0]           mem_addr_o;
  logic                  mem_rvalid_i;
  logic [31:0]           mem_rdata_i;
  logic                  commit_valid_o;
  logic [31:0]           commit_pc_o;
  logic                  commit_wx_en_o;
  logic [4:0]            commit_wx_addr_o;
  logic [31:0]           commit_wx_o;
  logic                  err_o;

  always #5 clk = ~clk;

  spec_step_seq #(
    .NREGS         (NREGS),
    .MemGrans      (MG),
    .ResetPc       (32'h0000_0080),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .instr_valid_i    (instr_valid_i),
    .instr_ready_o    (instr_ready_o),
    .instr_bits_i     (instr_bits_i),
    .instr_mode_i     (instr_mode_i),
    .spec_regs_o      (spec_regs_o),
    .spec_pc_o        (spec_pc_o),
    .spec_insn_o      (spec_insn_o),
    .spec_mode_o      (spec_mode_o),
    .spec_mem_rdata_o (spec_mem_rdata_o),
    .spec_wx_en_i     (spec_wx_en_i),
    .spec_wx_addr_i   (spec_wx_addr_i),
    .spec_wx_i        (spec_wx_i),
    .spec_nextpc_i    (spec_nextpc_i),
    .spec_err_i       (spec_err_i),
    .spec_mem_req_i   (spec_mem_req_i),
    .spec_mem_addr_i  (spec_mem_addr_i),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_rvalid_i     (mem_rvalid_i),
    .mem_rdata_i      (mem_rdata_i),
    .commit_valid_o   (commit_valid_o),
    .commit_pc_o      (commit_pc_o),
    .commit_wx_en_o   (commit_wx_en_o),
    .commit_wx_addr_o (commit_wx_addr_o),
    .commit_wx_o      (commit_wx_o),
    .err_o            (err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_at(input int idx);
    return spec_regs_o[(idx-1)*32 +: 32];
  endfunction

  typedef struct {
    logic [31:0] bits;
    logic [1:0]  mode;
    logic        wx_en;
    logic [4:0]  wx_addr;
    logic [31:0] wx_data;
    logic [31:0] nextpc;
    logic [31:0] exp_cpc;
    logic        exp_wen;
    int          chk_idx;
    logic [31:0] chk_val;
  } vec_t;

  vec_t vecs [5];

  task automatic do_reset();
    @(negedge clk);
    rst_i         = 1'b1;
    instr_valid_i = 1'b0;
    mem_rvalid_i  = 1'b0;
    spec_err_i    = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i           = 1'b1;
    instr_valid_i   = 1'b0;
    instr_bits_i    = '0;
    instr_mode_i    = '0;
    spec_wx_en_i    = 1'b0;
    spec_wx_addr_i  = '0;
    spec_wx_i       = '0;
    spec_nextpc_i   = '0;
    spec_err_i      = 1'b0;
    spec_mem_req_i  = '0;
    spec_mem_addr_i = {32'h0000_1004, 32'h0000_1000};
    mem_rvalid_i    = 1'b0;
    mem_rdata_i     = '0;

    //             bits          mode  en addr  data           nextpc        cpc           wen idx val
    vecs[0] = '{32'h0050_0093, 2'd0, 1'b1, 5'd1,  32'd5,         32'h84,  32'h80,  1'b1, 1,  32'd5};
    vecs[1] = '{32'h1234_0013, 2'd1, 1'b1, 5'd0,  32'h1234,      32'h88,  32'h84,  1'b0, 1,  32'd5};
    vecs[2] = '{32'h0000_0013, 2'd2, 1'b0, 5'd3,  32'hDEAD,      32'h8C,  32'h88,  1'b0, 3,  32'd0};
    vecs[3] = '{32'h0000_0F93, 2'd3, 1'b1, 5'd31, 32'hCAFE_F00D, 32'h200, 32'h8C,  1'b1, 31, 32'hCAFE_F00D};
    vecs[4] = '{32'hFFF0_0093, 2'd0, 1'b1, 5'd1,  32'hFFFF_FFFF, 32'h204, 32'h200, 1'b1, 1,  32'hFFFF_FFFF};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", instr_ready_o, 1);
    check("rst_pc", spec_pc_o, 32'h80);
    check("rst_err", err_o, 0);
    check("rst_commit", commit_valid_o, 0);
    check("rst_memreq", mem_req_o, 0);
    check("rst_rdata", spec_mem_rdata_o, 0);
    @(negedge clk);
    rst_i = 1'b0;

    // Table of single-cycle-execute instructions
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      instr_valid_i  = 1'b1;
      instr_bits_i   = vecs[i].bits;
      instr_mode_i   = vecs[i].mode;
      spec_wx_en_i   = vecs[i].wx_en;
      spec_wx_addr_i = vecs[i].wx_addr;
      spec_wx_i      = vecs[i].wx_data;
      spec_nextpc_i  = vecs[i].nextpc;
      spec_mem_req_i = '0;
      #1 check($sformatf("v%0d_ready_idle", i), instr_ready_o, 1);
      @(negedge clk);
      instr_valid_i = 1'b0;
      #1;
      check($sformatf("v%0d_ready_exec", i), instr_ready_o, 0);
      check($sformatf("v%0d_commit_exec", i), commit_valid_o, 0);
      check($sformatf("v%0d_insn", i), spec_insn_o, vecs[i].bits);
      check($sformatf("v%0d_mode", i), spec_mode_o, vecs[i].mode);
      @(negedge clk);
      #1;
      check($sformatf("v%0d_commit", i), commit_valid_o, 1);
      check($sformatf("v%0d_cpc", i), commit_pc_o, vecs[i].exp_cpc);
      check($sformatf("v%0d_cwen", i), commit_wx_en_o, vecs[i].exp_wen);
      check($sformatf("v%0d_caddr", i), commit_wx_addr_o, vecs[i].wx_addr);
      check($sformatf("v%0d_cdata", i), commit_wx_o, vecs[i].wx_data);
      @(negedge clk);
      #1;
      check($sformatf("v%0d_commit_done", i), commit_valid_o, 0);
      check($sformatf("v%0d_pc", i), spec_pc_o, vecs[i].nextpc);
      check($sformatf("v%0d_reg", i), reg_at(vecs[i].chk_idx), vecs[i].chk_val);
    end

    // Two-granule read
    @(negedge clk);
    instr_valid_i  = 1'b1;
    instr_bits_i   = 32'h0000_A103;
    spec_mem_req_i = 2'b11;
    spec_wx_en_i   = 1'b1;
    spec_wx_addr_i = 5'd2;
    spec_wx_i      = 32'h55;
    spec_nextpc_i  = 32'h208;
    @(negedge clk);
    instr_valid_i = 1'b0;
    #1 check("m_memreq_exec", mem_req_o, 0);
    @(negedge clk);
    #1;
    check("m_memreq_wait", mem_req_o, 1);
    check("m_addr0_wait", mem_addr_o, 32'h1000);
    @(negedge clk);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hAABB_CCDD;
    #1 check("m_addr0", mem_addr_o, 32'h1000);
    @(negedge clk);
    mem_rdata_i = 32'h1122_3344;
    #1;
    check("m_addr1", mem_addr_o, 32'h1004);
    check("m_rdata_half", spec_mem_rdata_o, 64'h0000_0000_AABB_CCDD);
    check("m_commit_early", commit_valid_o, 0);
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #1;
    check("m_commit", commit_valid_o, 1);
    check("m_cpc", commit_pc_o, 32'h204);
    check("m_rdata", spec_mem_rdata_o, 64'h1122_3344_AABB_CCDD);
    check("m_memreq_commit", mem_req_o, 0);
    @(negedge clk);
    #1;
    check("m_pc", spec_pc_o, 32'h208);
    check("m_reg2", reg_at(2), 32'h55);

    // Reset in MEM_WAIT with one granule collected
    @(negedge clk);
    instr_valid_i = 1'b1;
    spec_wx_en_i  = 1'b0;
    @(negedge clk);
    instr_valid_i = 1'b0;
    @(negedge clk);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h99;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    rst_i        = 1'b1;
    #1;
    check("r_commit_under_rst", commit_valid_o, 0);
    check("r_ready_under_rst", instr_ready_o, 1);
    check("r_pc_under_rst", spec_pc_o, 32'h80);
    check("r_memreq_under_rst", mem_req_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("r_ready", instr_ready_o, 1);
    check("r_pc", spec_pc_o, 32'h80);
    check("r_rdata", spec_mem_rdata_o, 0);
    check("r_reg1", reg_at(1), 0);
    check("r_commit", commit_valid_o, 0);
    // Counter restarted at granule 0
    @(negedge clk);
    instr_valid_i  = 1'b1;
    spec_mem_req_i = 2'b01;
    spec_nextpc_i  = 32'h300;
    @(negedge clk);
    instr_valid_i = 1'b0;
    @(negedge clk);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h77;
    #1 check("r_addr_k0", mem_addr_o, 32'h1000);
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #1;
    check("r1_commit", commit_valid_o, 1);
    check("r1_cpc", commit_pc_o, 32'h80);
    check("r1_rdata", spec_mem_rdata_o, 64'h77);
    @(negedge clk);
    #1 check("r1_pc", spec_pc_o, 32'h300);

    // spec_err_i in EXEC
    spec_mem_req_i = '0;
    instr_valid_i  = 1'b1;
    @(negedge clk);
    instr_valid_i = 1'b0;
    spec_err_i    = 1'b1;
    #1 check("e_commit_exec", commit_valid_o, 0);
    @(negedge clk);
    spec_err_i    = 1'b0;
    instr_valid_i = 1'b1;
    #1;
    check("e_err", err_o, 1);
    check("e_ready", instr_ready_o, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("e_err_sticky%0d", c), err_o, 1);
      check($sformatf("e_commit_sticky%0d", c), commit_valid_o, 0);
    end
    do_reset();
    #1;
    check("e_err_cleared", err_o, 0);
    check("e_ready_after_rst", instr_ready_o, 1);

    // Non-contiguous request mask
    instr_valid_i  = 1'b1;
    spec_mem_req_i = 2'b10;
    @(negedge clk);
    instr_valid_i = 1'b0;
    @(negedge clk);
    #1;
    check("nc_err", err_o, 1);
    check("nc_memreq", mem_req_o, 0);
    do_reset();

    // rvalid outside MEM_WAIT
    mem_rvalid_i = 1'b1;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #1 check("rv_idle_err", err_o, 1);
    do_reset();

    // MEM_WAIT with no data returned
    instr_valid_i  = 1'b1;
    spec_mem_req_i = 2'b11;
    @(negedge clk);
    instr_valid_i = 1'b0;
`ifdef SPEC_STEP_MEM_TIMEOUT_EN
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      #1;
      if (c == TO) check("to_still_waiting", mem_req_o, 1);
    end
    @(negedge clk);
    #1;
    check("to_err", err_o, 1);
    check("to_memreq", mem_req_o, 0);
`else
    repeat (100) @(negedge clk);
    #1;
    check("nto_waiting", mem_req_o, 1);
    check("nto_err", err_o, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
